// File: rtl/issue_queue_multi.sv
// Out-of-order issue queue: tag wakeup from NUM_WB ports, per-FU oldest-first
// select with backpressure, flush, and a valid/ready dispatch handshake.
module issue_queue_multi #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 3,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  parameter int PKT_W  = 7 + PREG_W + 3*DATA_W + ROB_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [6:0]                 disp_opcode,
  input  logic [PREG_W-1:0]          disp_rd,
  input  logic [PREG_W-1:0]          disp_rs1,
  input  logic [PREG_W-1:0]          disp_rs2,
  input  logic                       disp_rs1_rdy,
  input  logic                       disp_rs2_rdy,
  input  logic [DATA_W-1:0]          disp_rs1_val,
  input  logic [DATA_W-1:0]          disp_rs2_val,
  input  logic [DATA_W-1:0]          disp_imm,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic [FU_W-1:0]            disp_fu,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          issue_valid,
  output logic [NUM_FU*PKT_W-1:0]    issue_pkt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // Returns {hit, value}; the lowest-numbered matching port wins.
  function automatic logic [DATA_W:0] wb_lookup(
    input logic [PREG_W-1:0]        tag,
    input logic [NUM_WB-1:0]        vld,
    input logic [NUM_WB*PREG_W-1:0] tags,
    input logic [NUM_WB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_WB-1; k >= 0; k--) begin
      if (vld[k] && (tags[k*PREG_W +: PREG_W] == tag)) res = {1'b1, data[k*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        older_q [DEPTH];
  logic [DEPTH-1:0]        older_d [DEPTH];
  logic [FU_W-1:0]         fu_q [DEPTH];
  logic [FU_W-1:0]         fu_d [DEPTH];
  logic [PREG_W-1:0]       rs1_tag_q [DEPTH];
  logic [PREG_W-1:0]       rs1_tag_d [DEPTH];
  logic [PREG_W-1:0]       rs2_tag_q [DEPTH];
  logic [PREG_W-1:0]       rs2_tag_d [DEPTH];
  logic [PREG_W-1:0]       rd_q [DEPTH];
  logic [PREG_W-1:0]       rd_d [DEPTH];
  logic [DEPTH-1:0]        rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [DATA_W-1:0]       rs1_val_q [DEPTH];
  logic [DATA_W-1:0]       rs1_val_d [DEPTH];
  logic [DATA_W-1:0]       rs2_val_q [DEPTH];
  logic [DATA_W-1:0]       rs2_val_d [DEPTH];
  logic [DATA_W-1:0]       imm_q [DEPTH];
  logic [DATA_W-1:0]       imm_d [DEPTH];
  logic [6:0]              opc_q [DEPTH];
  logic [6:0]              opc_d [DEPTH];
  logic [ROB_W-1:0]        rob_q [DEPTH];
  logic [ROB_W-1:0]        rob_d [DEPTH];
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [NUM_FU-1:0]       issue_valid_q, issue_valid_d;
  logic [NUM_FU*PKT_W-1:0] issue_pkt_q, issue_pkt_d;

  logic [DEPTH-1:0]  wk1_hit, wk2_hit, elig, issue_mask;
  logic [DATA_W-1:0] wk1_val [DEPTH];
  logic [DATA_W-1:0] wk2_val [DEPTH];
  logic [DEPTH-1:0]  cand [NUM_FU];
  logic [DEPTH-1:0]  sel [NUM_FU];
  logic [NUM_FU-1:0] issue_go;
  logic [OCC_W-1:0]  iss_cnt;
  logic [IDX_W-1:0]  free_idx;
  logic              disp_fire;
  logic [DATA_W:0]   cap1, cap2;

  assign disp_ready  = (occ_q < OCC_W'(DEPTH));
  assign occupancy   = occ_q;
  assign issue_valid = issue_valid_q;
  assign issue_pkt   = issue_pkt_q;

  // Wakeup match per source; a same-cycle match counts toward eligibility.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wk1_hit[i], wk1_val[i]} = wb_lookup(rs1_tag_q[i], wb_valid, wb_tag, wb_data);
      {wk2_hit[i], wk2_val[i]} = wb_lookup(rs2_tag_q[i], wb_valid, wb_tag, wb_data);
      elig[i] = valid_q[i] && (rs1_rdy_q[i] || wk1_hit[i]) && (rs2_rdy_q[i] || wk2_hit[i]);
    end
  end

  // older_q[i][j] set means entry j was dispatched before entry i.
  always_comb begin
    issue_mask = '0;
    iss_cnt    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      cand[f] = '0;
      sel[f]  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cand[f][i] = elig[i] && fu_ready[f] && (fu_q[i] == FU_W'(f));
      end
      for (int i = 0; i < DEPTH; i++) begin
        sel[f][i] = cand[f][i] && !(|(cand[f] & older_q[i]));
      end
      issue_go[f] = (|sel[f]) && !flush;
      issue_mask  = issue_mask | sel[f];
      iss_cnt     = iss_cnt + OCC_W'(issue_go[f]);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    disp_fire = disp_valid && disp_ready && !flush;
    cap1      = wb_lookup(disp_rs1, wb_valid, wb_tag, wb_data);
    cap2      = wb_lookup(disp_rs2, wb_valid, wb_tag, wb_data);
  end

  always_comb begin
    valid_d   = valid_q & ~issue_mask;
    older_d   = older_q;
    fu_d      = fu_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rd_d      = rd_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    opc_d     = opc_q;
    rob_d     = rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !rs1_rdy_q[i] && wk1_hit[i]) begin
        rs1_rdy_d[i] = 1'b1;
        rs1_val_d[i] = wk1_val[i];
      end
      if (valid_q[i] && !rs2_rdy_q[i] && wk2_hit[i]) begin
        rs2_rdy_d[i] = 1'b1;
        rs2_val_d[i] = wk2_val[i];
      end
    end
    if (disp_fire) begin
      valid_d[free_idx]   = 1'b1;
      fu_d[free_idx]      = disp_fu;
      rs1_tag_d[free_idx] = disp_rs1;
      rs2_tag_d[free_idx] = disp_rs2;
      rd_d[free_idx]      = disp_rd;
      rs1_rdy_d[free_idx] = disp_rs1_rdy || cap1[DATA_W];
      rs2_rdy_d[free_idx] = disp_rs2_rdy || cap2[DATA_W];
      rs1_val_d[free_idx] = disp_rs1_rdy ? disp_rs1_val : cap1[DATA_W-1:0];
      rs2_val_d[free_idx] = disp_rs2_rdy ? disp_rs2_val : cap2[DATA_W-1:0];
      imm_d[free_idx]     = disp_imm;
      opc_d[free_idx]     = disp_opcode;
      rob_d[free_idx]     = disp_rob;
      // Everything still resident is older than the newcomer.
      older_d[free_idx]   = valid_q & ~issue_mask;
      for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
    end
    occ_d = occ_q + OCC_W'(disp_fire) - iss_cnt;
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_comb begin
    issue_valid_d = issue_go;
    issue_pkt_d   = issue_pkt_q;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_go[f] && sel[f][i]) begin
          issue_pkt_d[f*PKT_W +: PKT_W] = {opc_q[i], rd_q[i],
                                           rs1_rdy_q[i] ? rs1_val_q[i] : wk1_val[i],
                                           rs2_rdy_q[i] ? rs2_val_q[i] : wk2_val[i],
                                           imm_q[i], rob_q[i]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      occ_q         <= '0;
      issue_valid_q <= '0;
      issue_pkt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      valid_q       <= valid_d;
      occ_q         <= occ_d;
      issue_valid_q <= issue_valid_d;
      issue_pkt_q   <= issue_pkt_d;
      older_q       <= older_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    fu_q      <= fu_d;
    rs1_tag_q <= rs1_tag_d;
    rs2_tag_q <= rs2_tag_d;
    rd_q      <= rd_d;
    rs1_rdy_q <= rs1_rdy_d;
    rs2_rdy_q <= rs2_rdy_d;
    rs1_val_q <= rs1_val_d;
    rs2_val_q <= rs2_val_d;
    imm_q     <= imm_d;
    opc_q     <= opc_d;
    rob_q     <= rob_d;
  end

endmodule

// File: doc/issue_queue_multi.md
# issue_queue_multi

Parametrised out-of-order issue queue that sits between register-read/rename and the functional units. It buffers up to DEPTH dispatched instructions and captures operands from NUM_WB writeback/forward ports. Each cycle it issues at most one instruction per functional unit, choosing the oldest ready instruction. It generalises the single-forward, round-robin queue with the following additions:

- explicit FU steering
- per-FU backpressure
- oldest-first select
- flush
- a valid/ready dispatch handshake

## Interface
Parameters:
- DEPTH, 16: number of entries; any value ≥2.
- NUM_FU, 3: functional units, one issue port each.
- NUM_WB, 3: writeback/wakeup ports.
- PREG_W, 6: physical register tag width.
- DATA_W, 32: operand width.
- ROB_W, 6: ROB index width.
- FU_W, $clog2(NUM_FU): FU select width (minimum 1).
- PKT_W, 7+PREG_W+3*DATA_W+ROB_W: issue packet width.

Ports:
- clk  in  1  clock. All state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept this cycle.
- disp_opcode  in  7  opcode.
- disp_rd  in  PREG_W  destination tag.
- disp_rs1, disp_rs2  in  PREG_W  source tags.
- disp_rs1_rdy, disp_rs2_rdy  in  1  source value already valid.
- disp_rs1_val, disp_rs2_val  in  DATA_W  source values; ignored when the matching rdy bit is 0.
- disp_imm  in  DATA_W  immediate.
- disp_rob  in  ROB_W  ROB index.
- disp_fu  in  FU_W  target FU. Must be < NUM_FU.
- wb_valid  in  NUM_WB  wakeup strobes.
- wb_tag  in  NUM_WB*PREG_W  wakeup tags. Port k occupies [k*PREG_W +: PREG_W].
- wb_data  in  NUM_WB*DATA_W  wakeup values, packed the same way.
- fu_ready  in  NUM_FU  FU f can accept an issue next cycle.
- issue_valid  out  NUM_FU  registered issue strobe per FU.
- issue_pkt  out  NUM_FU*PKT_W  per FU, packed {opcode, rd, rs1_val, rs2_val, imm, rob}, MSB first.
- occupancy  out  $clog2(DEPTH+1)  count of valid entries.

## Operation
- Entry state: valid, age, fu, rs1/rs2 tag, rdy bit, value, opcode, rd, imm, rob.
- Dispatch:
  - Handshake completes when disp_valid && disp_ready && !flush.
  - disp_ready = (occupancy < DEPTH). It depends only on registered state, not on same-cycle issues.
  - The lowest-index free entry is written.
- Dispatch capture: if a source is not ready and any wb_valid[k] with wb_tag[k] == that source tag is asserted in the dispatch cycle, the entry is written with rdy=1 and the wb_data value.
- Wakeup: every valid entry compares both source tags against all NUM_WB ports every cycle.
  - On a match, rdy is set and the value is latched.
  - If multiple ports match the same tag, the lowest k wins.
  - Already-ready sources are never overwritten.
- Eligibility: an entry is eligible when it is valid and each source is either already rdy or woken this cycle (same-cycle bypass; the forwarded value goes into the packet).
  - An entry is not eligible in its own dispatch cycle.
- Select: for each FU f with fu_ready[f]=1, pick the oldest eligible entry whose fu == f.
  - Age is strict dispatch order, so ties cannot occur.
  - The selected entry frees at the clock edge. issue_valid[f] and issue_pkt[f] are registered at the same edge.
- If fu_ready[f]=0, no FU-f entry issues. Entries for other FUs are unaffected.
- issue_valid[f] is a one-cycle pulse per issued instruction. issue_pkt[f] holds its last value when not valid.
- occupancy_next = occupancy + dispatch − number of issues.
- Flush:
  - All valid bits clear, occupancy → 0, issue_valid → 0 at the next edge.
  - A dispatch in the flush cycle is dropped.
  - flush takes priority over select.
- Reset has the same effect as flush. It also clears issue_pkt to 0 and the age state.

## Timing
- Reset values: disp_ready=1 (after the reset edge), issue_valid=0, issue_pkt=0, occupancy=0.
- Dispatch at edge E with both sources ready → earliest issue_valid at edge E+1 (visible in the cycle after E+1).
- Wakeup at cycle N for an entry whose last pending source it is → issue_valid asserted after edge N, provided fu_ready was high and the entry is oldest.
- Full: at occupancy==DEPTH, disp_ready=0 even if an issue frees an entry in the same cycle. It recovers the following cycle.
- Simultaneous dispatch and issue in the same cycle: occupancy is unchanged.
- Reset asserted mid-operation: all in-flight state is discarded at that edge and no issue occurs.

## Test plan
- Reset, then dispatch 3 ready instructions to FU0 (rob 1, 2, 3) in consecutive cycles with fu_ready=3'b111 → FU0 issues rob 1, 2, 3 in order, one per cycle. occupancy peaks at 1.
- Dispatch rob 5 (rs1=12 not ready, FU1). Two cycles later drive wb_valid[2]=1, wb_tag[2]=12, wb_data[2]=32'hDEADBEEF → issue_valid[1] on the next edge with rs1_val=32'hDEADBEEF, rob 5.
- Hold fu_ready[0]=0 and dispatch rob 7 then rob 8 (both ready, FU0) → no issue. Release fu_ready[0] → rob 7 issues first, then rob 8.
- Fill all 16 entries with sources not ready (DEPTH=16) → disp_ready=0, occupancy=16. One wakeup issues one entry; disp_ready stays 0 in that cycle and returns to 1 on the next.
- Dispatch with rs2=20 not ready in the same cycle as wb_valid[0] with tag 20 and value 7 → entry captures 7 and issues at the next edge.
- Hold 4 entries, then assert flush together with disp_valid → occupancy=0 next cycle, no issue_valid, and the dropped instruction never issues.
